// File: rtl/pipelined_split_multiplier_if.sv
// Valid/ready operand and result stream for pipelined_split_multiplier.
// slave = multiplier side, master = producer/consumer side.
interface pipelined_split_multiplier_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic [TAG_W-1:0]   out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/pipelined_split_multiplier.sv
// 3-stage unsigned multiplier built from a one-level high/low operand split.
// Define APPROX_MID_ADD_EN to make the low APPROX_BITS of the middle sum carry-free.
module pipelined_split_multiplier #(
    parameter int WIDTH       = 16,
    parameter int SPLIT       = 7,
    parameter int TAG_W       = 4,
    parameter int APPROX_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    pipelined_split_multiplier_if.slave bus
);
    localparam int HW = WIDTH - SPLIT;
`ifdef APPROX_MID_ADD_EN
    localparam bit APPROX_MODE = 1'b1;
`else
    localparam bit APPROX_MODE = 1'b0;
`endif
    localparam int AB = APPROX_MODE ? APPROX_BITS : 0;

    logic [3:1]           vld_pipe_q;
    logic [2*HW-1:0]      hh_q, hh_d;
    logic [WIDTH-1:0]     hl_q, hl_d, lh_q, lh_d;
    logic [2*SPLIT-1:0]   ll_q, ll_d;
    logic [TAG_W-1:0]     tag1_q, tag2_q, tag3_q;
    logic [WIDTH:0]       mid_q, mid_d;
    logic [2*WIDTH-1:0]   cat_q, p_q, p_d, mid_ext;
    logic                 adv;

    logic [HW-1:0]    a_h, b_h;
    logic [SPLIT-1:0] a_l, b_l;

    assign adv = !vld_pipe_q[3] || bus.out_ready;

    assign a_h = bus.in_a[WIDTH-1:SPLIT];
    assign b_h = bus.in_b[WIDTH-1:SPLIT];
    assign a_l = bus.in_a[SPLIT-1:0];
    assign b_l = bus.in_b[SPLIT-1:0];

    assign hh_d = {{HW{1'b0}}, a_h} * {{HW{1'b0}}, b_h};
    assign hl_d = {{SPLIT{1'b0}}, a_h} * {{HW{1'b0}}, b_l};
    assign lh_d = {{HW{1'b0}}, a_l} * {{SPLIT{1'b0}}, b_h};
    assign ll_d = {{SPLIT{1'b0}}, a_l} * {{SPLIT{1'b0}}, b_l};

    // Middle adder: exact, fully carry-free, or split carry-free low / exact high.
    generate
        if (AB == 0) begin : g_mid_exact
            assign mid_d = {1'b0, hl_q} + {1'b0, lh_q};
        end else if (AB >= WIDTH) begin : g_mid_or
            assign mid_d = {1'b0, hl_q | lh_q};
        end else begin : g_mid_approx
            assign mid_d = {({1'b0, hl_q[WIDTH-1:AB]} + {1'b0, lh_q[WIDTH-1:AB]}),
                            (hl_q[AB-1:0] | lh_q[AB-1:0])};
        end
    endgenerate

    assign mid_ext = {{(WIDTH-1){1'b0}}, mid_q};
    assign p_d     = cat_q + (mid_ext << SPLIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            hh_q       <= '0;
            hl_q       <= '0;
            lh_q       <= '0;
            ll_q       <= '0;
            tag1_q     <= '0;
            mid_q      <= '0;
            cat_q      <= '0;
            tag2_q     <= '0;
            p_q        <= '0;
            tag3_q     <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[2:1], bus.in_valid};
            hh_q       <= hh_d;
            hl_q       <= hl_d;
            lh_q       <= lh_d;
            ll_q       <= ll_d;
            tag1_q     <= bus.in_tag;
            mid_q      <= mid_d;
            cat_q      <= {hh_q, ll_q};
            tag2_q     <= tag1_q;
            p_q        <= p_d;
            tag3_q     <= tag2_q;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe_q[3];
    assign bus.out_p     = p_q;
    assign bus.out_tag   = tag3_q;
endmodule

// File: tb/tb_pipelined_split_multiplier.sv
// Directed and randomized checks of pipelined_split_multiplier (WIDTH=16, SPLIT=7).
module tb_pipelined_split_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    bit   sb_en = 1'b0;

    always #5 clk = ~clk;

    pipelined_split_multiplier_if #(.WIDTH(16), .TAG_W(4)) bus ();

    pipelined_split_multiplier #(
        .WIDTH(16), .SPLIT(7), .TAG_W(4), .APPROX_BITS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference product, straight from the operand-split definition.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef APPROX_MID_ADD_EN
        logic [31:0] ah, al, bh, bl, hl, lh, mid;
        ah  = {23'd0, a[15:7]};  al = {25'd0, a[6:0]};
        bh  = {23'd0, b[15:7]};  bl = {25'd0, b[6:0]};
        hl  = ah * bl;
        lh  = al * bh;
        mid = (((hl >> 4) + (lh >> 4)) << 4) | ((hl | lh) & 32'hF);
        return ((ah * bh) << 14) + (mid << 7) + al * bl;
`else
        return {16'd0, a} * {16'd0, b};
`endif
    endfunction

    logic [31:0] exp_q[$];
    logic [3:0]  tag_q[$];

    always @(posedge clk) begin
        if (sb_en && !rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("rnd_extra", 64'd1, 64'd0);
                else begin
                    chk("rnd_p", {32'd0, bus.out_p}, {32'd0, exp_q.pop_front()});
                    chk("rnd_tag", {60'd0, bus.out_tag}, {60'd0, tag_q.pop_front()});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_a, bus.in_b));
                tag_q.push_back(bus.in_tag);
            end
        end
    end

    task automatic single(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] t, input logic [31:0] exp);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_tag = t;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({nm, "_lat1"}, {63'd0, bus.out_valid}, 64'd0);
        step();
        chk({nm, "_lat2"}, {63'd0, bus.out_valid}, 64'd0);
        step();
        chk({nm, "_vld"}, {63'd0, bus.out_valid}, 64'd1);
        chk({nm, "_p"}, {32'd0, bus.out_p}, {32'd0, exp});
        chk({nm, "_tag"}, {60'd0, bus.out_tag}, {60'd0, t});
        step();
        chk({nm, "_once"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    logic [15:0] sa[4] = '{16'd3, 16'h0080, 16'h1234, 16'd0};
    logic [15:0] sb[4] = '{16'd5, 16'h0080, 16'h0001, 16'hBEEF};
    logic [31:0] sp[4] = '{32'd15, 32'h4000, 32'h1234, 32'd0};
    logic [15:0] ba[4] = '{16'd2, 16'd100, 16'h8000, 16'hABCD};
    logic [15:0] bb[4] = '{16'd3, 16'd7, 16'd2, 16'h0010};
    logic [31:0] bp[4] = '{32'd6, 32'd700, 32'h10000, 32'hABCD0};

    initial begin
        int k;
        bus.in_valid = 1'b1; bus.in_a = 16'h1111; bus.in_b = 16'h2222;
        bus.in_tag = 4'h3; bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("rst_vld", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_p", {32'd0, bus.out_p}, 64'd0);
        chk("rst_tag", {60'd0, bus.out_tag}, 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_rdy", {63'd0, bus.in_ready}, 64'd1);
        step();
        chk("rst_rdy2", {63'd0, bus.in_ready}, 64'd1);

        single("max", 16'hFFFF, 16'hFFFF, 4'hA, 32'hFFFE0001);

        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                bus.in_valid = 1'b1; bus.in_a = sa[c]; bus.in_b = sb[c];
                bus.in_tag = 4'(c + 1);
            end else bus.in_valid = 1'b0;
            step();
            if (c >= 2 && c <= 5) begin
                chk("str_vld", {63'd0, bus.out_valid}, 64'd1);
                chk("str_p", {32'd0, bus.out_p}, {32'd0, sp[c-2]});
                chk("str_tag", {60'd0, bus.out_tag}, 64'(c - 1));
            end else if (c == 6) chk("str_end", {63'd0, bus.out_valid}, 64'd0);
        end

        // Fill the pipe against a stalled consumer, then release it.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1; bus.in_a = ba[c]; bus.in_b = bb[c]; bus.in_tag = 4'(c + 1);
            step();
        end
        bus.in_a = ba[3]; bus.in_b = bb[3]; bus.in_tag = 4'd4;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rdy", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_vld", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_hold_p", {32'd0, bus.out_p}, {32'd0, bp[0]});
            chk("bp_hold_tag", {60'd0, bus.out_tag}, 64'd1);
            step();
        end
        bus.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid) begin
                if (k < 4) begin
                    chk("bp_p", {32'd0, bus.out_p}, {32'd0, bp[k]});
                    chk("bp_tag", {60'd0, bus.out_tag}, 64'(k + 1));
                end
                k++;
            end
            step();
            bus.in_valid = 1'b0;
        end
        chk("bp_count", 64'(k), 64'd4);

`ifdef APPROX_MID_ADD_EN
        single("mid", 16'h00FF, 16'h00FF, 4'h6, 32'h0000F681);
`else
        single("mid", 16'h00FF, 16'h00FF, 4'h6, 32'h0000FE01);
`endif

        bus.in_valid = 1'b1; bus.in_a = 16'd9; bus.in_b = 16'd9; bus.in_tag = 4'h1;
        step();
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("rmid_idle", {63'd0, bus.out_valid}, 64'd0);
            step();
        end
        single("rmid_new", 16'd7, 16'd6, 4'h5, 32'd42);

        sb_en = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_a      = 16'($urandom);
            bus.in_b      = 16'($urandom);
            bus.in_tag    = 4'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        chk("rnd_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
